// File: rtl/pc_unit.sv
// Program-counter unit: holds the fetch PC, advances it under a valid/ready
// handshake, and applies jump/branch redirects with deferred branch resolution.
module pc_unit #(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] BOOT_ADDR   = XLEN'(32'h0000_0080),
    parameter int              INSTR_BYTES = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            en_i,
    input  logic            boot_i,
    output logic [XLEN-1:0] pc_o,
    output logic            pc_valid_o,
    input  logic            pc_ready_i,
    input  logic            br_valid_i,
    output logic            br_ready_o,
    input  logic [XLEN-1:0] operand_a_i,
    input  logic [XLEN-1:0] operand_b_i,
    input  logic            branch_bool_i,
    input  logic            cmp_valid_i,
    input  logic            op_bool_i,
    output logic            redirect_o,
    output logic            misalign_o
);

    typedef enum logic [1:0] {
        ST_BOOT     = 2'd0,
        ST_RUN      = 2'd1,
        ST_WAIT_CMP = 2'd2
    } state_e;

    localparam logic [XLEN-1:0] STEP = XLEN'(INSTR_BYTES);

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] tgt_q, tgt_d;
    logic            redirect_q, redirect_d;
    logic            misalign_q, misalign_d;

    logic [XLEN-1:0] tgt_now;
    logic            tgt_now_mis;
    logic            tgt_q_mis;
    logic [XLEN-1:0] pc_seq;

    // Bit 0 is always dropped; bit 1 only matters for 4-byte instructions.
    assign tgt_now     = (operand_a_i + operand_b_i) & ~XLEN'(1);
    assign tgt_now_mis = (INSTR_BYTES == 4) && tgt_now[1];
    assign tgt_q_mis   = (INSTR_BYTES == 4) && tgt_q[1];
    assign pc_seq      = pc_q + STEP;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_BOOT;
            pc_q       <= BOOT_ADDR;
            tgt_q      <= '0;
            redirect_q <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            tgt_q      <= tgt_d;
            redirect_q <= redirect_d;
            misalign_q <= misalign_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        tgt_d      = tgt_q;
        redirect_d = 1'b0;
        misalign_d = 1'b0;
        if (boot_i) begin
            state_d = ST_BOOT;
            pc_d    = BOOT_ADDR;
            tgt_d   = '0;
        end else if (en_i) begin
            unique case (state_q)
                ST_BOOT: begin
                    state_d = ST_RUN;
                end
                ST_RUN: begin
                    if (pc_ready_i) begin
                        pc_d = pc_seq;
                    end
                    if (br_valid_i) begin
                        if (branch_bool_i) begin
                            tgt_d   = tgt_now;
                            state_d = ST_WAIT_CMP;
                        end else if (tgt_now_mis) begin
                            misalign_d = 1'b1;
                        end else begin
                            // A redirect overrides the same-cycle sequential step.
                            pc_d       = tgt_now;
                            redirect_d = 1'b1;
                        end
                    end
                end
                ST_WAIT_CMP: begin
                    if (cmp_valid_i) begin
                        state_d = ST_RUN;
                        if (op_bool_i) begin
                            if (tgt_q_mis) begin
                                misalign_d = 1'b1;
                            end else begin
                                pc_d       = tgt_q;
                                redirect_d = 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    state_d = ST_BOOT;
                end
            endcase
        end
    end

    always_comb begin
        pc_valid_o = (state_q == ST_RUN);
        br_ready_o = (state_q == ST_RUN);
        pc_o       = pc_q;
        redirect_o = redirect_q;
        misalign_o = misalign_q;
    end

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit; a second instance with 2-byte instructions
// shares the inputs and is only inspected in the misalignment scenario.
module tb_pc_unit;

    logic        clk = 1'b0;
    logic        rst_i, en_i, boot_i, pc_ready_i, br_valid_i, branch_bool_i, cmp_valid_i, op_bool_i;
    logic [31:0] operand_a_i, operand_b_i;
    logic [31:0] pc_o, pc2_o;
    logic        pc_valid_o, br_ready_o, redirect_o, misalign_o;
    logic        pc_valid2_o, br_ready2_o, redirect2_o, misalign2_o;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pc_unit #(.XLEN(32), .BOOT_ADDR(32'h0000_0080), .INSTR_BYTES(4)) dut (
        .clk_i(clk), .rst_i(rst_i), .en_i(en_i), .boot_i(boot_i),
        .pc_o(pc_o), .pc_valid_o(pc_valid_o), .pc_ready_i(pc_ready_i),
        .br_valid_i(br_valid_i), .br_ready_o(br_ready_o),
        .operand_a_i(operand_a_i), .operand_b_i(operand_b_i),
        .branch_bool_i(branch_bool_i), .cmp_valid_i(cmp_valid_i), .op_bool_i(op_bool_i),
        .redirect_o(redirect_o), .misalign_o(misalign_o)
    );

    pc_unit #(.XLEN(32), .BOOT_ADDR(32'h0000_0080), .INSTR_BYTES(2)) dut2 (
        .clk_i(clk), .rst_i(rst_i), .en_i(en_i), .boot_i(boot_i),
        .pc_o(pc2_o), .pc_valid_o(pc_valid2_o), .pc_ready_i(pc_ready_i),
        .br_valid_i(br_valid_i), .br_ready_o(br_ready2_o),
        .operand_a_i(operand_a_i), .operand_b_i(operand_b_i),
        .branch_bool_i(branch_bool_i), .cmp_valid_i(cmp_valid_i), .op_bool_i(op_bool_i),
        .redirect_o(redirect2_o), .misalign_o(misalign2_o)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        boot_i = 0; pc_ready_i = 0; br_valid_i = 0; branch_bool_i = 0;
        cmp_valid_i = 0; op_bool_i = 0; operand_a_i = '0; operand_b_i = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_i = 1; en_i = 0;
        tick(); tick();
        rst_i = 0;
        tick();
        checks++; if (pc_o !== 32'h80) begin failures++; $display("FAIL reset_pc got=%h exp=%h", pc_o, 32'h80); end
        checks++; if (pc_valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", pc_valid_o); end
        checks++; if (br_ready_o !== 1'b0) begin failures++; $display("FAIL reset_br_ready got=%b exp=0", br_ready_o); end
        checks++; if ({redirect_o, misalign_o} !== 2'b00) begin failures++; $display("FAIL reset_pulses got=%b exp=00", {redirect_o, misalign_o}); end
        en_i = 1;
        tick();
        checks++; if (pc_valid_o !== 1'b1) begin failures++; $display("FAIL boot_to_run_valid got=%b exp=1", pc_valid_o); end
        checks++; if (br_ready_o !== 1'b1) begin failures++; $display("FAIL boot_to_run_br_ready got=%b exp=1", br_ready_o); end
        checks++; if (pc_o !== 32'h80) begin failures++; $display("FAIL boot_to_run_pc got=%h exp=%h", pc_o, 32'h80); end
    endtask

    task automatic test_sequential();
        logic [31:0] exp_pc;
        exp_pc = 32'h80;
        pc_ready_i = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            exp_pc = exp_pc + 32'd4;
            checks++; if (pc_o !== exp_pc) begin failures++; $display("FAIL seq_step%0d got=%h exp=%h", i, pc_o, exp_pc); end
        end
        pc_ready_i = 0;
        tick(); tick();
        checks++; if (pc_o !== 32'h8C) begin failures++; $display("FAIL seq_hold got=%h exp=%h", pc_o, 32'h8C); end
    endtask

    task automatic test_jump();
        br_valid_i = 1; branch_bool_i = 0; operand_a_i = 32'd1; operand_b_i = 32'd32; pc_ready_i = 1;
        tick();
        br_valid_i = 0; pc_ready_i = 0;
        checks++; if (pc_o !== 32'h20) begin failures++; $display("FAIL jump_pc got=%h exp=%h", pc_o, 32'h20); end
        checks++; if (redirect_o !== 1'b1) begin failures++; $display("FAIL jump_redirect got=%b exp=1", redirect_o); end
        checks++; if (misalign_o !== 1'b0) begin failures++; $display("FAIL jump_misalign got=%b exp=0", misalign_o); end
        tick();
        checks++; if (redirect_o !== 1'b0) begin failures++; $display("FAIL jump_redirect_drop got=%b exp=0", redirect_o); end
        checks++; if (pc_o !== 32'h20) begin failures++; $display("FAIL jump_pc_hold got=%h exp=%h", pc_o, 32'h20); end
    endtask

    task automatic test_cond_branch();
        // taken, fetch not ready at acceptance
        br_valid_i = 1; branch_bool_i = 1; operand_a_i = 32'h100; operand_b_i = 32'h10;
        tick();
        br_valid_i = 0;
        checks++; if ({pc_valid_o, br_ready_o} !== 2'b00) begin failures++; $display("FAIL br_stall got=%b exp=00", {pc_valid_o, br_ready_o}); end
        checks++; if (pc_o !== 32'h20) begin failures++; $display("FAIL br_stall_pc got=%h exp=%h", pc_o, 32'h20); end
        br_valid_i = 1; operand_a_i = 32'h500;  // ignored while waiting
        tick();
        br_valid_i = 0;
        checks++; if ({pc_valid_o, br_ready_o, redirect_o} !== 3'b000) begin failures++; $display("FAIL br_stall2 got=%b exp=000", {pc_valid_o, br_ready_o, redirect_o}); end
        cmp_valid_i = 1; op_bool_i = 1;
        tick();
        cmp_valid_i = 0; op_bool_i = 0;
        checks++; if (pc_o !== 32'h110) begin failures++; $display("FAIL br_taken_pc got=%h exp=%h", pc_o, 32'h110); end
        checks++; if ({redirect_o, pc_valid_o} !== 2'b11) begin failures++; $display("FAIL br_taken_flags got=%b exp=11", {redirect_o, pc_valid_o}); end
        tick();
        checks++; if (redirect_o !== 1'b0) begin failures++; $display("FAIL br_taken_pulse got=%b exp=0", redirect_o); end
        // not taken, with a same-cycle fetch handshake at acceptance
        br_valid_i = 1; branch_bool_i = 1; operand_a_i = 32'h100; operand_b_i = 32'h10; pc_ready_i = 1;
        tick();
        br_valid_i = 0; pc_ready_i = 0;
        checks++; if (pc_o !== 32'h114) begin failures++; $display("FAIL br_accept_adv got=%h exp=%h", pc_o, 32'h114); end
        cmp_valid_i = 1; op_bool_i = 0;
        tick();
        cmp_valid_i = 0;
        checks++; if (pc_o !== 32'h114) begin failures++; $display("FAIL br_not_taken_pc got=%h exp=%h", pc_o, 32'h114); end
        checks++; if ({redirect_o, misalign_o, pc_valid_o} !== 3'b001) begin failures++; $display("FAIL br_not_taken_flags got=%b exp=001", {redirect_o, misalign_o, pc_valid_o}); end
    endtask

    task automatic test_misalign();
        rst_i = 1; idle_inputs();
        tick();
        rst_i = 0; en_i = 1;
        tick();
        br_valid_i = 1; branch_bool_i = 0; operand_a_i = 32'd2; operand_b_i = 32'd0;
        tick();
        br_valid_i = 0;
        checks++; if (pc_o !== 32'h80) begin failures++; $display("FAIL mis_pc got=%h exp=%h", pc_o, 32'h80); end
        checks++; if ({misalign_o, redirect_o} !== 2'b10) begin failures++; $display("FAIL mis_flags got=%b exp=10", {misalign_o, redirect_o}); end
        checks++; if (pc2_o !== 32'h2) begin failures++; $display("FAIL ib2_pc got=%h exp=%h", pc2_o, 32'h2); end
        checks++; if ({misalign2_o, redirect2_o} !== 2'b01) begin failures++; $display("FAIL ib2_flags got=%b exp=01", {misalign2_o, redirect2_o}); end
        tick();
        checks++; if (misalign_o !== 1'b0) begin failures++; $display("FAIL mis_pulse got=%b exp=0", misalign_o); end
        // misaligned jump with ready: pc still steps
        br_valid_i = 1; operand_a_i = 32'd7; operand_b_i = 32'd3; pc_ready_i = 1;
        tick();
        br_valid_i = 0; pc_ready_i = 0;
        checks++; if ({pc_o, misalign_o, redirect_o} !== {32'h84, 2'b10}) begin failures++; $display("FAIL mis_adv got=%h/%b%b exp=84/10", pc_o, misalign_o, redirect_o); end
        // misaligned conditional target resolved taken
        br_valid_i = 1; branch_bool_i = 1; operand_a_i = 32'd6; operand_b_i = 32'd0;
        tick();
        br_valid_i = 0; cmp_valid_i = 1; op_bool_i = 1;
        tick();
        cmp_valid_i = 0; op_bool_i = 0;
        checks++; if ({pc_o, misalign_o, redirect_o} !== {32'h84, 2'b10}) begin failures++; $display("FAIL mis_br got=%h/%b%b exp=84/10", pc_o, misalign_o, redirect_o); end
    endtask

    task automatic test_wrap();
        br_valid_i = 1; branch_bool_i = 0; operand_a_i = 32'hFFFF_FFF0; operand_b_i = 32'hC;
        tick();
        br_valid_i = 0;
        checks++; if (pc_o !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_jump got=%h exp=%h", pc_o, 32'hFFFF_FFFC); end
        pc_ready_i = 1;
        tick();
        pc_ready_i = 0;
        checks++; if ({pc_o, redirect_o, misalign_o} !== {32'h0, 2'b00}) begin failures++; $display("FAIL wrap_step got=%h/%b%b exp=0/00", pc_o, redirect_o, misalign_o); end
    endtask

    task automatic test_boot();
        br_valid_i = 1; branch_bool_i = 1; operand_a_i = 32'h100; operand_b_i = 32'h10;
        tick();
        br_valid_i = 0; boot_i = 1;
        tick();
        boot_i = 0;
        checks++; if ({pc_o, pc_valid_o, redirect_o} !== {32'h80, 2'b00}) begin failures++; $display("FAIL boot_pc got=%h/%b%b exp=80/00", pc_o, pc_valid_o, redirect_o); end
        cmp_valid_i = 1; op_bool_i = 1;
        tick();
        checks++; if ({pc_o, pc_valid_o, redirect_o} !== {32'h80, 2'b10}) begin failures++; $display("FAIL boot_stale1 got=%h/%b%b exp=80/10", pc_o, pc_valid_o, redirect_o); end
        tick();
        cmp_valid_i = 0; op_bool_i = 0;
        checks++; if ({pc_o, redirect_o} !== {32'h80, 1'b0}) begin failures++; $display("FAIL boot_stale2 got=%h/%b exp=80/0", pc_o, redirect_o); end
    endtask

    task automatic test_freeze();
        br_valid_i = 1; branch_bool_i = 1; operand_a_i = 32'h200; operand_b_i = 32'h0;
        tick();
        br_valid_i = 0; en_i = 0; cmp_valid_i = 1; op_bool_i = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if ({pc_o, pc_valid_o, redirect_o} !== {32'h80, 2'b00}) begin failures++; $display("FAIL freeze_wait%0d got=%h/%b%b exp=80/00", i, pc_o, pc_valid_o, redirect_o); end
        end
        en_i = 1;
        tick();
        cmp_valid_i = 0; op_bool_i = 0;
        checks++; if ({pc_o, redirect_o} !== {32'h200, 1'b1}) begin failures++; $display("FAIL freeze_resume got=%h/%b exp=200/1", pc_o, redirect_o); end
        en_i = 0; pc_ready_i = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if ({pc_o, pc_valid_o} !== {32'h200, 1'b1}) begin failures++; $display("FAIL freeze_run%0d got=%h/%b exp=200/1", i, pc_o, pc_valid_o); end
        end
        en_i = 1;
        tick();
        pc_ready_i = 0;
        checks++; if (pc_o !== 32'h204) begin failures++; $display("FAIL freeze_run_resume got=%h exp=%h", pc_o, 32'h204); end
    endtask

    task automatic test_back_to_back();
        br_valid_i = 1; branch_bool_i = 0; operand_a_i = 32'h300; operand_b_i = 32'h0;
        tick();
        checks++; if ({pc_o, redirect_o} !== {32'h300, 1'b1}) begin failures++; $display("FAIL b2b_first got=%h/%b exp=300/1", pc_o, redirect_o); end
        operand_a_i = 32'h400; operand_b_i = 32'h8;
        tick();
        br_valid_i = 0;
        checks++; if ({pc_o, redirect_o} !== {32'h408, 1'b1}) begin failures++; $display("FAIL b2b_second got=%h/%b exp=408/1", pc_o, redirect_o); end
        tick();
        checks++; if (redirect_o !== 1'b0) begin failures++; $display("FAIL b2b_end got=%b exp=0", redirect_o); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_jump();
        test_cond_branch();
        test_misalign();
        test_wrap();
        test_boot();
        test_freeze();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
